// File: rtl/hilo_muldiv.sv
// EX-stage HI/LO register file with single-cycle MULT/MULTU and a handshake
// controller for the external iterative divider (start/annul/ready).
module hilo_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_DIV_WAIT, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  drain_cnt_q, drain_cnt_d;
    logic [31:0] op1_q, op1_d, op2_q, op2_d;
    logic        sgn_q, sgn_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        act, is_div, alu_en;
    logic [63:0] prod_s, prod_u;

    assign act    = valid_i & ~flush_i;
    assign is_div = (op_i == OP_DIV) || (op_i == OP_DIVU);

    // 64x64 products of extended operands; the low 64 bits are the exact result.
    assign prod_s = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
    assign prod_u = {32'b0, rs_i} * {32'b0, rt_i};

    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign div_annul_o = flush_i;

    always_comb begin
        case (op_i)
            OP_MFHI: rdata_o = hi_q;
            OP_MFLO: rdata_o = lo_q;
            default: rdata_o = 32'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        sgn_d        = sgn_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        stall_o      = 1'b0;
        div_start_o  = 1'b0;
        div_signed_o = 1'b0;
        div_op1_o    = 32'b0;
        div_op2_o    = 32'b0;
        alu_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                alu_en = 1'b1;
                if (act && is_div) begin
                    div_start_o  = 1'b1;
                    div_op1_o    = rs_i;
                    div_op2_o    = rt_i;
                    div_signed_o = (op_i == OP_DIV);
                    op1_d        = rs_i;
                    op2_d        = rt_i;
                    sgn_d        = (op_i == OP_DIV);
                    stall_o      = 1'b1;
                    state_d      = S_DIV_WAIT;
                end
            end
            S_DIV_WAIT: begin
                div_start_o  = 1'b1;
                div_op1_o    = op1_q;
                div_op2_o    = op2_q;
                div_signed_o = sgn_q;
                if (flush_i) begin
                    div_start_o = 1'b0;
                    drain_cnt_d = 2'd2;
                    state_d     = S_DRAIN;
                end else if (div_ready_i) begin
                    div_start_o = 1'b0;
                    hi_d        = div_result_i[63:32];
                    lo_d        = div_result_i[31:0];
                    state_d     = S_IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            S_DRAIN: begin
                // Start held low so an annulled divider (even mid divide-by-zero) frees up.
                alu_en      = 1'b1;
                drain_cnt_d = drain_cnt_q - 2'd1;
                if (drain_cnt_d == 2'd0) state_d = S_IDLE;
                if (act && is_div) stall_o = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (alu_en && act) begin
            case (op_i)
                OP_MULT:  {hi_d, lo_d} = prod_s;
                OP_MULTU: {hi_d, lo_d} = prod_u;
                OP_MTHI:  hi_d = rs_i;
                OP_MTLO:  lo_d = rs_i;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= 2'd0;
            op1_q       <= 32'b0;
            op2_q       <= 32'b0;
            sgn_q       <= 1'b0;
            hi_q        <= 32'b0;
            lo_q        <= 32'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            sgn_q       <= sgn_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

endmodule
